// File: rtl/uart_rx_deserializer_if.sv
// Receive-side UART bundle: oversample tick and serial line in, framed byte and status out.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 en_rx;
    logic                 u_rx;
    logic [DATA_BITS-1:0] data_rx;
    logic                 rx_done;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output en_rx,
        output u_rx,
        input  data_rx,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  en_rx,
        input  u_rx,
        output data_rx,
        output rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes the line, validates the start bit at mid-bit,
// shifts in DATA_BITS LSB-first and checks the stop bit on oversample ticks.
module uart_rx_deserializer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_deserializer_if.slave  rx_if
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 r_armed;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sync  <= 2'b11;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx_if.u_rx};
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            if (rx_if.en_rx) begin
                case (r_state)
                    IDLE: begin
                        // A failed stop disarms until the line is seen high again.
                        if (w_rx_s) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= START;
                            r_tick  <= '0;
                        end
                    end
                    START: begin
                        if (r_tick == HALF_M1) begin
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    DATA: begin
                        if (r_tick == FULL_M1) begin
                            r_shift <= DATA_BITS'({w_rx_s, r_shift} >> 1);
                            r_tick  <= '0;
                            r_bit   <= r_bit + BW'(1);
                            if (r_bit == LAST_BIT) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    STOP: begin
                        if (r_tick == FULL_M1) begin
                            if (w_rx_s) begin
                                r_data <= r_shift;
                                r_done <= 1'b1;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_armed <= 1'b0;
                            end
                            r_state <= IDLE;
                            r_tick  <= '0;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rx_if.data_rx   = r_data;
    assign rx_if.rx_done   = r_done;
    assign rx_if.frame_err = r_ferr;
    assign rx_if.rx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: a serial-line driver feeds directed and random
// frames, a frame-level model queues expected strobes, a monitor pops and compares.
module tb_uart_rx_deserializer;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_deserializer #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx_if(rx_if)
    );

    typedef struct {
        bit                   is_err;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    exp_t                 sb[$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    int unsigned          div = 1;
    logic [DATA_BITS-1:0] last_good = '0;
    longint               cyc = 0;
    longint               start_cyc = 0;
    longint               done_cyc = -1;
    bit                   mon_en = 1'b0;
    logic                 prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One oversample tick: en_rx pulses for one clk every div clocks.
    task automatic tick();
        repeat (div - 1) begin
            rx_if.en_rx = 1'b0;
            @(negedge clk);
        end
        rx_if.en_rx = 1'b1;
        @(negedge clk);
        rx_if.en_rx = 1'b0;
    endtask

    task automatic line_bit(input logic v);
        rx_if.u_rx = v;
        repeat (OVERSAMPLE) tick();
    endtask

    task automatic idle(input int n);
        rx_if.u_rx = 1'b1;
        repeat (n) tick();
    endtask

    // Model: a good stop delivers the byte; a bad stop reports an error and keeps the old byte.
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        if (stop) last_good = d;
        sb.push_back(e);
        start_cyc = cyc;
        line_bit(1'b0);
        for (int i = 0; i < int'(DATA_BITS); i++) line_bit(d[i]);
        line_bit(stop);
    endtask

    always @(negedge clk) begin
        if (mon_en && (rx_if.rx_done || rx_if.frame_err)) begin
            check("strobe_exclusive", longint'(rx_if.rx_done & rx_if.frame_err), 0);
            check("done_width", longint'(rx_if.rx_done & prev_done), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got done=%0b err=%0b want none at cycle %0d",
                         rx_if.rx_done, rx_if.frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind_err", longint'(rx_if.frame_err), longint'(e.is_err));
                check("data_rx", longint'(rx_if.data_rx), longint'(e.data));
            end
            if (rx_if.rx_done) done_cyc = cyc;
        end
        prev_done = rx_if.rx_done;
    end

    initial begin
        int                   busy_cnt;
        logic [DATA_BITS-1:0] d;
        logic                 stop;

        rx_if.en_rx = 1'b0;
        rx_if.u_rx  = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_rx", longint'(rx_if.data_rx), 0);
        check("rst_rx_done", longint'(rx_if.rx_done), 0);
        check("rst_frame_err", longint'(rx_if.frame_err), 0);
        check("rst_rx_busy", longint'(rx_if.rx_busy), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 0xA5 with a tick every clk; start seen on the 3rd edge after the drop, done 152 ticks later.
        div = 1;
        idle(20);
        send_frame(8'hA5, 1'b1);
        idle(24);
        check("latency_cycles", done_cyc - start_cyc, 155);
        check("data_after_a5", longint'(rx_if.data_rx), 8'hA5);

        // Start glitch: four low ticks must give exactly eight busy ticks and no strobe.
        idle(32);
        busy_cnt = 0;
        rx_if.u_rx = 1'b0;
        repeat (4) begin
            tick();
            busy_cnt += int'(rx_if.rx_busy);
        end
        rx_if.u_rx = 1'b1;
        repeat (20) begin
            tick();
            busy_cnt += int'(rx_if.rx_busy);
        end
        check("glitch_busy_ticks", busy_cnt, 8);
        check("glitch_data_kept", longint'(rx_if.data_rx), 8'hA5);

        // Bad stop followed by a held break: one error only, then a clean frame.
        send_frame(8'h3C, 1'b0);
        rx_if.u_rx = 1'b0;
        repeat (40) tick();
        idle(32);
        check("data_after_break", longint'(rx_if.data_rx), 8'hA5);
        send_frame(8'h5A, 1'b1);
        idle(24);

        // Back-to-back frames with no idle gap and a tick every 4th clk.
        div = 4;
        idle(8);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(24);
        check("data_after_b2b", longint'(rx_if.data_rx), 8'hFF);

        // Reset during data bit 3 of 0x81 discards the frame.
        div = 1;
        idle(16);
        rx_if.u_rx = 1'b0;
        repeat (OVERSAMPLE) tick();
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b0);
        rx_if.u_rx = 1'b0;
        repeat (OVERSAMPLE / 2) tick();
        rst_n = 1'b0;
        rx_if.u_rx = 1'b1;
        @(negedge clk);
        check("midrst_data_rx", longint'(rx_if.data_rx), 0);
        check("midrst_rx_busy", longint'(rx_if.rx_busy), 0);
        check("midrst_rx_done", longint'(rx_if.rx_done), 0);
        check("midrst_frame_err", longint'(rx_if.frame_err), 0);
        rst_n = 1'b1;
        last_good = '0;
        idle(32);
        send_frame(8'h42, 1'b1);
        idle(24);

        // Random frames, tick rates, stop errors and idle gaps.
        repeat (24) begin
            div  = $urandom_range(1, 4);
            d    = DATA_BITS'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop);
            idle(stop ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 20)));
        end
        idle(24);

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
